cordic_result_serializer: RTL
=============================

// Module: cordic_result_serializer
// PURPOSE
//  Downstream stage of the CORDIC mode controller. Captures each 48-bit result word
//  {tag[15:0], value[31:0]}, qualified by its one-cycle wr_en strobe, into a small FIFO.
//  Serialises each word MSB-first as 6 bytes over a valid/ready byte stream feeding the UART TX.
//  The controller has no backpressure input, so buffering and overflow reporting happen here.
// PARAMETERS
//  DEPTH    4   result FIFO depth in words; power of 2, >=2
//  BYTES    6   bytes per word (48/8); fixed by word format, not for override
// PORTS
//  clk       in   1    single system clock, all logic on posedge
//  reset     in   1    synchronous, active-high
//  wr_en     in   1    result strobe, one cycle per word
//  wr_data   in   48   result word: [47:32] tag, [31:0] value
//  tx_data   out  8    byte to UART TX
//  tx_valid  out  1    tx_data valid
//  tx_ready  in   1    UART TX accepts byte when high with tx_valid
//  busy      out  1    high while a word is loaded or the FIFO is non-empty
//  level     out  $clog2(DEPTH)+1  FIFO occupancy in words (excludes the word being sent)
//  overflow  out  1    sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: tx_data=0, tx_valid=0, busy=0, level=0, overflow=0, FIFO pointers=0, FSM=S_IDLE.
//    Reset wins over every other event in the same cycle.
//  Reset mid-word abandons the word in flight; any partial frame on the stream is tolerated.
//  Write: wr_en=1 sampled with (level<DEPTH) or (pop in the same cycle) -> word pushed.
//    Otherwise the word is dropped and overflow<=1; overflow holds until reset.
//    Push and pop in the same cycle leave level unchanged.
//  FSM S_IDLE: tx_valid=0. When FIFO is non-empty: load head into shreg[47:0], pop,
//    byte_cnt<=0, tx_valid<=1, go to S_SEND.
//  FSM S_SEND: tx_data=shreg[47:40].
//    On tx_valid && tx_ready with byte_cnt<5: shreg<<=8, byte_cnt++.
//    On the handshake with byte_cnt==5 and FIFO non-empty: load and pop the next word in
//      the same cycle (no bubble between words), byte_cnt<=0, tx_valid stays 1.
//    On the handshake with byte_cnt==5 and FIFO empty: tx_valid<=0, go to S_IDLE.
//  Stream rule: while tx_valid && !tx_ready, tx_data and tx_valid stay stable.
//    tx_valid never drops without a handshake.
//  Latency: with FIFO empty and FSM in S_IDLE, wr_en sampled at edge k gives tx_valid=1
//    and tx_data=wr_data[47:40] after edge k+1.
//  Throughput: 1 byte/cycle with tx_ready held high, i.e. 6 cycles/word sustained.
//  Byte order per word: [47:40],[39:32],[31:24],[23:16],[15:8],[7:0].
//  byte_cnt is 3 bits and never exceeds 5. FIFO pointers are $clog2(DEPTH) bits and wrap
//    naturally; full/empty come from level, not from pointer compare.
//  busy = (state==S_SEND) | (level!=0).
//  Word contents are not inspected; a tag of 0 is transmitted like any other word.
// STRUCTURE
//  Shared header/package cordic_pkg:
//    RESULT_W=48
//    TAG_SIN_ASIN=16'h000a, TAG_TANH_ATAN=16'h000b, TAG_COS_ACOS=16'h000c,
//    TAG_SQRT=16'h000d, TAG_EXP=16'h000e, TAG_LN=16'h000f
//    FSM encodings S_IDLE=1'b0, S_SEND=1'b1
//  Sub-module cordic_result_fifo (sync FIFO, DEPTH x 48, push/pop/level/full/empty,
//    show-ahead head output). FSM and shift register live in this module.
// TESTING
//  1 Single word 48'h000a_3F80_0000, tx_ready=1: bytes 00,0A,3F,80,00,00 on 6 consecutive
//    cycles; tx_valid high after edge k+1; busy low after the last byte.
//  2 Backpressure: toggle tx_ready 1/0 per cycle on word 48'h000c_1234_5678:
//    tx_data holds during every ready=0 cycle; 6 bytes 00,0C,12,34,56,78 in order, none repeated.
//  3 Back-to-back: 3 words on consecutive wr_en cycles, tx_ready=1: 18 bytes on 18
//    contiguous cycles with no tx_valid gap; level peaks at 2.
//  4 Overflow: tx_ready=0, DEPTH=4, issue 6 strobes: first word loaded, next 4 queued
//    (level=4), 6th dropped, overflow=1; after release the 5 words drain intact and
//    overflow stays 1.
//  5 Full + push/pop same cycle: level=4, final byte handshake coincides with wr_en:
//    word accepted, overflow stays 0, level stays 4.
//  6 Reset mid-word after 3 bytes, tx_ready=1: next cycle tx_valid=0, level=0, overflow=0;
//    a new word sent afterwards starts at its byte [47:40].

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC result path: word format, result tags and
// serializer FSM states.
package cordic_pkg;

  localparam int unsigned RESULT_W     = 48;
  localparam int unsigned RESULT_BYTES = RESULT_W / 8;

  localparam logic [15:0] TAG_SIN_ASIN  = 16'h000a;
  localparam logic [15:0] TAG_TANH_ATAN = 16'h000b;
  localparam logic [15:0] TAG_COS_ACOS  = 16'h000c;
  localparam logic [15:0] TAG_SQRT      = 16'h000d;
  localparam logic [15:0] TAG_EXP       = 16'h000e;
  localparam logic [15:0] TAG_LN        = 16'h000f;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// Synchronous show-ahead FIFO of result words. Occupancy is tracked by a counter;
// full/empty derive from it so the pointers can wrap freely.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [RESULT_W-1:0]       push_data,
  input  logic                      pop,
  output logic [RESULT_W-1:0]       head,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  logic [RESULT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign level = count;
  assign full  = (count == DEPTH_L);
  assign empty = (count == '0);

endmodule

// File: rtl/cordic_result_serializer.sv
// Buffers 48-bit CORDIC results and streams each one MSB-first as six bytes over
// a valid/ready interface towards the UART transmitter.
module cordic_result_serializer
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [RESULT_W-1:0]    wr_data,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned BYTES = RESULT_BYTES;
  localparam logic [2:0]  LAST_BYTE = 3'(BYTES - 1);

  ser_state_t          state, state_nxt;
  logic [RESULT_W-1:0] shreg, shreg_nxt;
  logic [2:0]          byte_cnt, byte_cnt_nxt;
  logic                tx_valid_nxt;
  logic                handshake;

  logic                fifo_push;
  logic                fifo_pop;
  logic [RESULT_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;

  cordic_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign handshake = tx_valid & tx_ready;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign fifo_push = wr_en & (~fifo_full | fifo_pop);

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    byte_cnt_nxt = byte_cnt;
    tx_valid_nxt = tx_valid;
    fifo_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          shreg_nxt    = fifo_head;
          fifo_pop     = 1'b1;
          byte_cnt_nxt = '0;
          tx_valid_nxt = 1'b1;
          state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (byte_cnt != LAST_BYTE) begin
            shreg_nxt    = shreg << 8;
            byte_cnt_nxt = byte_cnt + 3'd1;
          end else if (!fifo_empty) begin
            // Chain straight into the next word so the stream has no bubble.
            shreg_nxt    = fifo_head;
            fifo_pop     = 1'b1;
            byte_cnt_nxt = '0;
          end else begin
            tx_valid_nxt = 1'b0;
            state_nxt    = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      tx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      byte_cnt <= byte_cnt_nxt;
      tx_valid <= tx_valid_nxt;
      if (wr_en && !fifo_push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign tx_data = shreg[RESULT_W-1 -: 8];
  assign busy    = (state == S_SEND) | (level != '0);

endmodule
